craft_sbox: RTL and testbench

CRAFT_SBOX -- requirements
Module: craft_sbox

---
 rtl/craft_sbox.sv | 92 +++++++++
 tb/tb_craft_sbox.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/craft_sbox.sv
// CRAFT 4-bit involutive S-box: one combinational lane plus a registered NIBBLES-wide layer.
// Optional registered state parity output is enabled by defining CRAFT_SBOX_PARITY_EN.
module craft_sbox #(
   parameter int NIBBLES = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [3:0]           din,
   output logic [3:0]           dout,
   input  logic                 valid_in,
   input  logic [4*NIBBLES-1:0] state_in,
   output logic [4*NIBBLES-1:0] state_out,
   output logic                 valid_out
`ifdef CRAFT_SBOX_PARITY_EN
   ,
   output logic                 parity_out
`endif
);

   // The table is its own inverse, so the same function serves both directions.
   function automatic logic [3:0] sbox_f(input logic [3:0] x);
      logic [3:0] y;
      y = 4'h0;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'hA;
         4'h2: y = 4'hD;
         4'h3: y = 4'h3;
         4'h4: y = 4'hE;
         4'h5: y = 4'hB;
         4'h6: y = 4'hF;
         4'h7: y = 4'h7;
         4'h8: y = 4'h8;
         4'h9: y = 4'h9;
         4'hA: y = 4'h1;
         4'hB: y = 4'h5;
         4'hC: y = 4'h0;
         4'hD: y = 4'h2;
         4'hE: y = 4'h4;
         4'hF: y = 4'h6;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   assign dout = sbox_f(din);

   logic [4*NIBBLES-1:0] sub_state;
   logic [4*NIBBLES-1:0] state_d, state_q;
   logic                 valid_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      sub_state = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         sub_state[4*i +: 4] = sbox_f(state_in[4*i +: 4]);
      end
      state_d = valid_in ? sub_state : state_q;
   end

`ifdef CRAFT_SBOX_PARITY_EN
   logic parity_d, parity_q;

   always_comb begin
      parity_d = valid_in ? ^sub_state : parity_q;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= '0;
         valid_q  <= 1'b0;
`ifdef CRAFT_SBOX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_in;
`ifdef CRAFT_SBOX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign state_out = state_q;
   assign valid_out = valid_q;
`ifdef CRAFT_SBOX_PARITY_EN
   assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_craft_sbox.sv
// Directed self-checking bench for craft_sbox (16 lanes), with optional parity checks
// when CRAFT_SBOX_PARITY_EN is defined.
module tb_craft_sbox;

   localparam int NIBBLES = 16;

   logic                 CLK;
   logic                 RST;
   logic [3:0]           din;
   logic [3:0]           dout;
   logic                 valid_in;
   logic [4*NIBBLES-1:0] state_in;
   logic [4*NIBBLES-1:0] state_out;
   logic                 valid_out;
`ifdef CRAFT_SBOX_PARITY_EN
   logic                 parity_out;
`endif

   int checks = 0;
   int errors = 0;

   craft_sbox #(.NIBBLES(NIBBLES)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .din       (din),
      .dout      (dout),
      .valid_in  (valid_in),
      .state_in  (state_in),
      .state_out (state_out),
      .valid_out (valid_out)
`ifdef CRAFT_SBOX_PARITY_EN
      ,
      .parity_out(parity_out)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [3:0] sbox_exp [16];

   initial begin
      sbox_exp = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                   4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};

      RST      = 1'b1;
      valid_in = 1'b0;
      state_in = '0;
      din      = 4'h0;

      // Reset takes effect without any clock edge.
      #1;
      check("reset_state_out", state_out, 64'h0);
      check("reset_valid_out", {63'b0, valid_out}, 64'h0);
`ifdef CRAFT_SBOX_PARITY_EN
      check("reset_parity_out", {63'b0, parity_out}, 64'h0);
`endif

      // Exhaustive single-lane sweep, held in reset to show dout ignores RST.
      for (int i = 0; i < 16; i++) begin
         din = 4'(i);
         #2;
         check($sformatf("dout_%0h", i), {60'b0, dout}, {60'b0, sbox_exp[i]});
      end

      din = 4'bxxxx;
      @(negedge CLK);
      RST = 1'b0;

      // Layer capture.
      state_in = 64'h0123456789ABCDEF;
      valid_in = 1'b1;
      @(posedge CLK); #1;
      check("capture_state", state_out, 64'hCAD3EBF789150246);
      check("capture_valid", {63'b0, valid_out}, 64'h1);
`ifdef CRAFT_SBOX_PARITY_EN
      check("capture_parity", {63'b0, parity_out}, 64'h0);
`endif

      // Involution: feed the result back.
      @(negedge CLK);
      state_in = 64'hCAD3EBF789150246;
      @(posedge CLK); #1;
      check("involution_state", state_out, 64'h0123456789ABCDEF);
      check("involution_valid", {63'b0, valid_out}, 64'h1);

      // Hold for three idle edges.
      @(negedge CLK);
      state_in = 64'hFFFFFFFFFFFFFFFF;
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK); #1;
         check($sformatf("hold_state_%0d", k), state_out, 64'h0123456789ABCDEF);
         check($sformatf("hold_valid_%0d", k), {63'b0, valid_out}, 64'h0);
      end

      @(negedge CLK);
      valid_in = 1'b1;
      @(posedge CLK); #1;
      check("all_f_state", state_out, 64'h6666666666666666);
      check("all_f_valid", {63'b0, valid_out}, 64'h1);

      // Lane independence with odd result parity: only lane 0 differs.
      @(negedge CLK);
      state_in = 64'h0000000000000002;
      @(posedge CLK); #1;
      check("lane0_state", state_out, 64'hCCCCCCCCCCCCCCCD);
`ifdef CRAFT_SBOX_PARITY_EN
      check("lane0_parity", {63'b0, parity_out}, 64'h1);
`endif

      // Async reset between edges while valid_out=1, with a capture pending.
      state_in = 64'h0123456789ABCDEF;
      din      = 4'h5;
      #2;
      RST = 1'b1;
      #1;
      check("async_rst_state", state_out, 64'h0);
      check("async_rst_valid", {63'b0, valid_out}, 64'h0);
`ifdef CRAFT_SBOX_PARITY_EN
      check("async_rst_parity", {63'b0, parity_out}, 64'h0);
`endif
      check("async_rst_dout", {60'b0, dout}, 64'hB);

      // An edge under reset with valid_in=1 must not capture.
      @(posedge CLK); #1;
      check("rst_edge_state", state_out, 64'h0);
      check("rst_edge_valid", {63'b0, valid_out}, 64'h0);

      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;
      check("post_rst_state", state_out, 64'hCAD3EBF789150246);
      check("post_rst_valid", {63'b0, valid_out}, 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
